// File: rtl/encode_jump_inst_if.sv
// encode_jump_inst_if
// Request/response bundle for the jump-instruction encoder.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid && ready are both high. The producer holds its payload steady while
// valid is high and ready is low; ready may depend on registered state only.
//
// Request side : in_valid, in_ready, rd, rs1, imm, jump_control
// Response side: out_valid, out_ready, out_instr
//
// Modports:
//   slave  - the encoder (consumes requests, produces instructions)
//   master - the environment (issues requests, takes instructions)
interface encode_jump_inst_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [20:0] imm;
    logic [1:0]  jump_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport slave (
        input  in_valid, rd, rs1, imm, jump_control, out_ready,
        output in_ready, out_valid, out_instr
    );

    modport master (
        output in_valid, rd, rs1, imm, jump_control, out_ready,
        input  in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/encode_jump_inst.sv
// encode_jump_inst
// Sequential encoder for RISC-V JAL/JALR instructions. A request is captured
// into a stage register, encoded and range-checked combinationally from that
// register, and legal words are pushed into a small output FIFO. Illegal
// requests are dropped, flagged with a one-cycle pulse and counted.
//
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset
//   bus         - encode_jump_inst_if.slave (request and instruction streams)
//   err_pulse   - high for the single cycle an illegal request sits in stage
//   enc_count   - legal instructions encoded, wraps
//   err_count   - illegal requests, saturates at 255
//   fifo_count  - current output FIFO occupancy
module encode_jump_inst #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    encode_jump_inst_if.slave             bus,
    output logic                          err_pulse,
    output logic [CNT_W-1:0]              enc_count,
    output logic [7:0]                    err_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // Stage register
    logic        stage_valid_q;
    logic [4:0]  stage_rd_q;
    logic [4:0]  stage_rs1_q;
    logic [20:0] stage_imm_q;
    logic [1:0]  stage_jc_q;

    // FIFO state
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;

    // Counters
    logic [CNT_W-1:0] enc_count_q;
    logic [7:0]       err_count_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             illegal;
    logic [31:0]      enc_word;
    logic [OCC_W-1:0] occupancy;

    // Credit counts the word still in stage, so the FIFO can never be asked
    // to take more than it has room for and stage 2 never needs to stall.
    // A pop in the same cycle is deliberately not counted as free space.
    assign occupancy    = count_q + OCC_W'(stage_valid_q);
    assign bus.in_ready = (occupancy < DEPTH_C);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = (count_q != '0);
    assign pop           = bus.out_valid && bus.out_ready;
    // Head word is read from registered storage; forced to 0 when empty so
    // stale entries are never visible.
    assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q] : 32'h0;

    // Encode and range-check from the stage register.
    always_comb begin
        enc_word = 32'h0;
        illegal  = 1'b1;
        unique case (stage_jc_q)
            2'b01: begin
                enc_word = {stage_imm_q[20], stage_imm_q[10:1], stage_imm_q[11],
                            stage_imm_q[19:12], stage_rd_q, OPC_JAL};
                // JAL targets are 2-byte aligned; bit 0 is not encodable.
                illegal  = stage_imm_q[0];
            end
            2'b10: begin
                enc_word = {stage_imm_q[11:0], stage_rs1_q, 3'b000, stage_rd_q, OPC_JALR};
                // Bits 20:11 must be a pure sign extension of bit 11.
                illegal  = !((&stage_imm_q[20:11]) || !(|stage_imm_q[20:11]));
            end
            default: begin
                enc_word = 32'h0;
                illegal  = 1'b1;
            end
        endcase
    end

    assign push      = stage_valid_q && !illegal;
    assign err_pulse = stage_valid_q && illegal;

    // Stage capture
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_valid_q <= 1'b0;
            stage_rd_q    <= '0;
            stage_rs1_q   <= '0;
            stage_imm_q   <= '0;
            stage_jc_q    <= '0;
        end else begin
            stage_valid_q <= accept;
            if (accept) begin
                stage_rd_q  <= bus.rd;
                stage_rs1_q <= bus.rs1;
                stage_imm_q <= bus.imm;
                stage_jc_q  <= bus.jump_control;
            end
        end
    end

    // FIFO storage; contents need no reset because the read side is gated
    // by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            if (push) begin
                enc_count_q <= enc_count_q + 1'b1;
            end
            if (err_pulse && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 1'b1;
            end
        end
    end

    assign enc_count  = enc_count_q;
    assign err_count  = err_count_q;
    assign fifo_count = count_q;

endmodule
